// File: rtl/pc_flow_ctrl_if.sv
// Fetch-flow control bundle between the decode/execute request side and the
// pc_flow_ctrl sequencer that steers PCIM and the decode flush.
interface pc_flow_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    // requests from decode/execute
    logic              jmp_req;
    logic              br_req;
    logic              br_taken;
    logic [ADDR_W-1:0] tgt;
    logic              ld_use;
    logic              halt_req;
    logic              resume;
    logic              cnt_clr;

    // controls to PCIM / decode, plus debug
    logic              pc_mux_sel;
    logic [ADDR_W-1:0] jmp_loc;
    logic              Stall;
    logic              Stall_pm;
    logic              flush;
    logic [2:0]        state;
    logic [15:0]       lost_cnt;

    modport master (
        output jmp_req, br_req, br_taken, tgt, ld_use, halt_req, resume, cnt_clr,
        input  pc_mux_sel, jmp_loc, Stall, Stall_pm, flush, state, lost_cnt
    );

    modport slave (
        input  jmp_req, br_req, br_taken, tgt, ld_use, halt_req, resume, cnt_clr,
        output pc_mux_sel, jmp_loc, Stall, Stall_pm, flush, state, lost_cnt
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Fetch-flow controller: sequences jump/branch redirects, load-use freezes and
// halt into PCIM control (pc_mux_sel, jmp_loc, Stall, Stall_pm) and a decode
// flush. Requests are only honoured in RUN. Keeps a saturating lost-cycle count.
module pc_flow_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned FLUSH_CYC    = 2,
    parameter int unsigned LD_STALL_CYC = 1
) (
    input  logic           clk,
    input  logic           reset,
    pc_flow_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        REDIR = 3'd1,
        FLUSH = 3'd2,
        LDSTL = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);
    localparam logic [3:0] LDSTL_LOAD = 4'(LD_STALL_CYC - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_pc_mux_sel;
    logic [ADDR_W-1:0] r_jmp_loc;
    logic              r_stall;
    logic              r_stall_pm;
    logic              r_flush;
    logic [15:0]       r_lost_cnt;

    logic              w_redirect;

    assign w_redirect = bus.jmp_req | (bus.br_req & bus.br_taken);

    // FSM: outputs are registered from the state being entered, so every
    // control line is valid for exactly the cycles spent in that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_pc_mux_sel <= 1'b0;
            r_jmp_loc    <= '0;
            r_stall      <= 1'b0;
            r_stall_pm   <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_pc_mux_sel <= 1'b0;
            r_stall      <= 1'b0;
            r_stall_pm   <= 1'b0;
            r_flush      <= 1'b0;
            case (r_state)
                RUN: begin
                    if (bus.halt_req) begin
                        r_state    <= HALT;
                        r_stall    <= 1'b1;
                        r_stall_pm <= 1'b1;
                        r_flush    <= 1'b1;
                    end else if (w_redirect) begin
                        r_state      <= REDIR;
                        r_jmp_loc    <= bus.tgt;
                        r_pc_mux_sel <= 1'b1;
                        r_flush      <= 1'b1;
                    end else if (bus.ld_use) begin
                        r_state    <= LDSTL;
                        r_cnt      <= LDSTL_LOAD;
                        r_stall    <= 1'b1;
                        r_stall_pm <= 1'b1;
                        r_flush    <= 1'b1;
                    end
                end
                REDIR: begin
                    r_state <= FLUSH;
                    r_cnt   <= FLUSH_LOAD;
                    r_flush <= 1'b1;
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_flush <= 1'b1;
                    end
                end
                LDSTL: begin
                    if (r_cnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_cnt      <= r_cnt - 4'd1;
                        r_stall    <= 1'b1;
                        r_stall_pm <= 1'b1;
                        r_flush    <= 1'b1;
                    end
                end
                HALT: begin
                    if (bus.resume) begin
                        r_state <= RUN;
                    end else begin
                        r_stall    <= 1'b1;
                        r_stall_pm <= 1'b1;
                        r_flush    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Lost-cycle counter: counts cycles already spent stalled or flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lost_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_lost_cnt <= '0;
        end else if ((r_stall | r_flush) && (r_lost_cnt != '1)) begin
            r_lost_cnt <= r_lost_cnt + 16'd1;
        end
    end

    assign bus.pc_mux_sel = r_pc_mux_sel;
    assign bus.jmp_loc    = r_jmp_loc;
    assign bus.Stall      = r_stall;
    assign bus.Stall_pm   = r_stall_pm;
    assign bus.flush      = r_flush;
    assign bus.state      = r_state;
    assign bus.lost_cnt   = r_lost_cnt;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: schedule-based reference model (each accepted
// request expands into a queue of per-cycle expected outputs), compared on
// every falling edge, plus directed literal checks.
module tb_pc_flow_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned FC = 2;
    localparam int unsigned LC = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pc_flow_ctrl_if #(.ADDR_W(AW)) bus();

    pc_flow_ctrl #(
        .ADDR_W      (AW),
        .FLUSH_CYC   (FC),
        .LD_STALL_CYC(LC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] st;
        logic       pm;
        logic       s;
        logic       spm;
        logic       f;
    } tup_t;

    function automatic tup_t mk(input logic [2:0] st, input logic pm, input logic s,
                                input logic spm, input logic f);
        tup_t t;
        t.st = st; t.pm = pm; t.s = s; t.spm = spm; t.f = f;
        return t;
    endfunction

    tup_t        q[$];
    tup_t        m_cur;
    logic [AW-1:0] m_jmp;
    int unsigned m_lost;
    bit          m_halt;

    initial begin
        m_cur  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_jmp  = '0;
        m_lost = 0;
        m_halt = 1'b0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q.delete();
                m_cur  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                m_jmp  = '0;
                m_lost = 0;
                m_halt = 1'b0;
            end else begin
                if (bus.cnt_clr)
                    m_lost = 0;
                else if ((m_cur.s || m_cur.f) && m_lost < 65535)
                    m_lost = m_lost + 1;

                if (q.size() > 0) begin
                    m_cur = q.pop_front();
                end else if (m_halt) begin
                    if (bus.resume) begin
                        m_halt = 1'b0;
                        m_cur  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                    end
                end else if (bus.halt_req) begin
                    m_halt = 1'b1;
                    m_cur  = mk(3'd4, 1'b0, 1'b1, 1'b1, 1'b1);
                end else if (bus.jmp_req || (bus.br_req && bus.br_taken)) begin
                    m_jmp = bus.tgt;
                    m_cur = mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
                    repeat (FC) q.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1));
                    q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                end else if (bus.ld_use) begin
                    m_cur = mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
                    repeat (LC - 1) q.push_back(mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b1));
                    q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("m_state",    32'(bus.state),      32'(m_cur.st));
            chk("m_pc_mux",   32'(bus.pc_mux_sel), 32'(m_cur.pm));
            chk("m_stall",    32'(bus.Stall),      32'(m_cur.s));
            chk("m_stall_pm", 32'(bus.Stall_pm),   32'(m_cur.spm));
            chk("m_flush",    32'(bus.flush),      32'(m_cur.f));
            chk("m_jmp_loc",  32'(bus.jmp_loc),    32'(m_jmp));
            chk("m_lost_cnt", 32'(bus.lost_cnt),   m_lost);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.jmp_req  = 1'b1;
        bus.br_req   = 1'b0;
        bus.br_taken = 1'b0;
        bus.tgt      = 8'h55;
        bus.ld_use   = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume   = 1'b0;
        bus.cnt_clr  = 1'b0;

        // reset held with a jump pending
        step(3);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pcmux", 32'(bus.pc_mux_sel), 32'd0);
        chk("rst_jmp",   32'(bus.jmp_loc), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_lost",  32'(bus.lost_cnt), 32'd0);
        reset = 1'b1;
        step(1);
        chk("rel_state", 32'(bus.state), 32'd1);
        chk("rel_jmp",   32'(bus.jmp_loc), 32'h55);
        bus.jmp_req = 1'b0;
        step(3);
        chk("rel_lost",  32'(bus.lost_cnt), 32'd3);
        bus.cnt_clr = 1'b1;
        step(1);
        bus.cnt_clr = 1'b0;
        chk("clr_lost",  32'(bus.lost_cnt), 32'd0);

        // jump: states 1,2,2,0 and 3 flush cycles
        bus.tgt = 8'h08; bus.jmp_req = 1'b1;
        step(1);
        chk("jmp_s1",    32'(bus.state), 32'd1);
        chk("jmp_pcmux", 32'(bus.pc_mux_sel), 32'd1);
        chk("jmp_loc",   32'(bus.jmp_loc), 32'h08);
        bus.jmp_req = 1'b0;
        step(1);
        chk("jmp_s2a",   32'(bus.state), 32'd2);
        chk("jmp_pcm0",  32'(bus.pc_mux_sel), 32'd0);
        step(1);
        chk("jmp_s2b",   32'(bus.state), 32'd2);
        step(1);
        chk("jmp_s0",    32'(bus.state), 32'd0);
        chk("jmp_fl0",   32'(bus.flush), 32'd0);
        chk("jmp_lost",  32'(bus.lost_cnt), 32'd3);

        // branch not taken, then taken
        bus.tgt = 8'h20; bus.br_req = 1'b1; bus.br_taken = 1'b0;
        step(2);
        chk("bnt_state", 32'(bus.state), 32'd0);
        chk("bnt_jmp",   32'(bus.jmp_loc), 32'h08);
        bus.br_taken = 1'b1;
        step(1);
        chk("bt_state",  32'(bus.state), 32'd1);
        chk("bt_jmp",    32'(bus.jmp_loc), 32'h20);
        bus.br_req = 1'b0; bus.br_taken = 1'b0;
        step(3);
        chk("bt_lost",   32'(bus.lost_cnt), 32'd6);

        // load-use single, then held (one RUN cycle between)
        bus.ld_use = 1'b1;
        step(1);
        chk("ld_state",  32'(bus.state), 32'd3);
        chk("ld_stall",  32'(bus.Stall), 32'd1);
        chk("ld_stpm",   32'(bus.Stall_pm), 32'd1);
        step(1);
        chk("ld_gap",    32'(bus.state), 32'd0);
        step(1);
        chk("ld_again",  32'(bus.state), 32'd3);
        bus.ld_use = 1'b0;
        step(1);
        chk("ld_lost",   32'(bus.lost_cnt), 32'd8);

        // ld_use + jump together: redirect wins, ld_use waits for RUN
        bus.ld_use = 1'b1; bus.jmp_req = 1'b1; bus.tgt = 8'h44;
        step(1);
        chk("lj_state",  32'(bus.state), 32'd1);
        chk("lj_stall",  32'(bus.Stall), 32'd0);
        bus.jmp_req = 1'b0;
        step(3);
        chk("lj_run",    32'(bus.state), 32'd0);
        step(1);
        chk("lj_ld",     32'(bus.state), 32'd3);
        bus.ld_use = 1'b0;
        step(1);
        chk("lj_lost",   32'(bus.lost_cnt), 32'd12);

        // halt + jump; resume at entry is not seen
        bus.halt_req = 1'b1; bus.jmp_req = 1'b1; bus.tgt = 8'h99; bus.resume = 1'b1;
        step(1);
        chk("h_state",   32'(bus.state), 32'd4);
        chk("h_pcmux",   32'(bus.pc_mux_sel), 32'd0);
        chk("h_jmp",     32'(bus.jmp_loc), 32'h44);
        bus.halt_req = 1'b0; bus.jmp_req = 1'b0; bus.resume = 1'b0;
        step(10);
        chk("h_stay",    32'(bus.state), 32'd4);
        chk("h_lost",    32'(bus.lost_cnt), 32'd22);
        bus.resume = 1'b1;
        step(1);
        chk("h_resume",  32'(bus.state), 32'd0);
        bus.resume = 1'b0;

        // saturation, then clear during a stall cycle
        bus.halt_req = 1'b1;
        step(1);
        bus.halt_req = 1'b0;
        step(70000);
        chk("sat_lost",  32'(bus.lost_cnt), 32'hFFFF);
        bus.cnt_clr = 1'b1;
        step(1);
        chk("sat_clr",   32'(bus.lost_cnt), 32'd0);
        bus.cnt_clr = 1'b0;
        step(1);
        chk("sat_inc",   32'(bus.lost_cnt), 32'd1);
        bus.resume = 1'b1;
        step(1);
        bus.resume = 1'b0;
        chk("sat_run",   32'(bus.state), 32'd0);

        // reset mid-FLUSH aborts at once
        bus.jmp_req = 1'b1; bus.tgt = 8'h12;
        step(1);
        bus.jmp_req = 1'b0;
        step(1);
        chk("mf_in",     32'(bus.state), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("mf_state",  32'(bus.state), 32'd0);
        chk("mf_flush",  32'(bus.flush), 32'd0);
        chk("mf_jmp",    32'(bus.jmp_loc), 32'd0);
        step(2);
        reset = 1'b1;
        step(2);
        chk("mf_after",  32'(bus.state), 32'd0);
        chk("mf_pcmux",  32'(bus.pc_mux_sel), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_flow_ctrl.md
# pc_flow_ctrl

Fetch-flow controller that drives the control inputs of the program-counter/instruction-memory block (`PCIM`): `pc_mux_sel`, `jmp_loc`, `Stall` and `Stall_pm`. It also drives a `flush` to the decode stage. Jump and branch-taken, load-use hazard and halt requests come from the decode/execute stages. The block sequences them through a small state machine into redirect, flush, stall and halt cycles. A saturating lost-cycle counter is kept for performance debug.

## Interface
- `ADDR_W`, 8, PC/jump-target width (matches `PCIM` `jmp_loc`)
- `FLUSH_CYC`, 2, bubble cycles after a redirect (1..15)
- `LD_STALL_CYC`, 1, freeze cycles per load-use hazard (1..15)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `jmp_req`  in  1  unconditional jump decoded in execute (level)
- `br_req`  in  1  conditional branch resolved this cycle (level)
- `br_taken`  in  1  branch outcome; qualified by `br_req`
- `tgt`  in  ADDR_W  jump/branch target address
- `ld_use`  in  1  load-use hazard detected in decode (level)
- `halt_req`  in  1  HLT instruction in execute (level)
- `resume`  in  1  leave HALT
- `cnt_clr`  in  1  synchronous clear of `lost_cnt`
- `pc_mux_sel`  out  1  1 = `PCIM` loads `jmp_loc` into PC
- `jmp_loc`  out  ADDR_W  redirect address to `PCIM`
- `Stall`  out  1  1 = PC holds
- `Stall_pm`  out  1  1 = fetched instruction register holds
- `flush`  out  1  1 = decode stage output replaced by NOP
- `state`  out  3  current FSM state (debug)
- `lost_cnt`  out  16  saturating count of cycles with `Stall` or `flush` high

## Operation
- States: RUN=0, REDIR=1, FLUSH=2, LDSTL=3, HALT=4. Encodings 5..7 are illegal and return to RUN on the next edge.
- Requests are sampled only in RUN. In every other state they are ignored, because the requesting stage is either frozen or flushed.
- Redirect condition: `jmp_req | (br_req & br_taken)`.
- A not-taken branch (`br_req & ~br_taken`) causes no action.
- Priority when requests are simultaneous in RUN: `halt_req` > redirect > `ld_use`.
- RUN transitions:
  - `halt_req` → HALT.
  - Redirect → REDIR, with `jmp_loc <= tgt` captured on the same edge.
  - `ld_use` → LDSTL, with the down-counter loaded to `LD_STALL_CYC-1`.
- REDIR (1 cycle):
  - Outputs: `pc_mux_sel`=1, `flush`=1, `Stall`=0, `Stall_pm`=0.
  - Next state: FLUSH with the counter loaded to `FLUSH_CYC-1`.
- FLUSH:
  - Outputs: `flush`=1, all else 0.
  - Returns to RUN when the counter reaches 0.
- LDSTL:
  - Outputs: `Stall`=1, `Stall_pm`=1, `flush`=1.
  - Returns to RUN when the counter reaches 0.
- HALT:
  - Outputs: `Stall`=1, `Stall_pm`=1, `flush`=1 while `resume`=0.
  - `resume`=1 → RUN on the next edge.
- RUN outputs: all control outputs 0. `jmp_loc` holds its last captured value.
- `lost_cnt`:
  - Increments by 1 on each edge where the registered `Stall|flush` is 1.
  - Saturates at 16'hFFFF.
  - `cnt_clr` has priority over increment and clears the count to 0.

## Timing
- All outputs are registered, derived from the next-state decode, so they change only on rising `clk` or asynchronous reset.
- Reset values (while `reset`=0):
  - `state`=RUN; `pc_mux_sel`=0, `jmp_loc`=0, `Stall`=0, `Stall_pm`=0, `flush`=0, `lost_cnt`=0; counter=0.
- Reset asserted mid-sequence (REDIR, FLUSH, LDSTL or HALT) aborts immediately to the reset values. No pending redirect survives.
- Redirect latency: request high before edge N → `pc_mux_sel`=1 during cycle N..N+1 → `PCIM` PC equals `tgt` after edge N+1.
- Cost per redirect: exactly 1+`FLUSH_CYC` cycles with `flush`=1.
- Cost per load-use hazard: exactly `LD_STALL_CYC` cycles with `Stall`=`Stall_pm`=1.
- A request held through the end of a sequence is re-sampled in the first RUN cycle. Back-to-back hazards therefore cost one RUN cycle between them.
- `resume` asserted in the same cycle as HALT entry is not seen. HALT lasts at least 1 cycle.

## Test plan
- Reset: hold `reset`=0 with `jmp_req`=1 → all outputs 0 and `state`=0. Release → `state`=1, `jmp_loc`=`tgt`, on the first edge.
- Jump: `tgt`=8'h08, `jmp_req` for 1 cycle → `pc_mux_sel`=1 for 1 cycle, then `flush`=1 for 3 cycles total; `state` sequence 0,1,2,2,0; `lost_cnt`=3.
- Branch: `br_req`=1 with `br_taken`=0 → no output change. Then `br_taken`=1, `tgt`=8'h20 → redirect to 8'h20.
- Load-use: `ld_use` for 1 cycle with `LD_STALL_CYC`=1 → `Stall`=`Stall_pm`=`flush`=1 for 1 cycle. Simultaneous `ld_use`+`jmp_req` → redirect only; `ld_use` is ignored until RUN.
- Halt: `halt_req`+`jmp_req` together → HALT with `pc_mux_sel`=0. Stay 10 cycles → `lost_cnt` +10. `resume` → RUN next edge.
- Counter: force 70000 stall cycles → `lost_cnt`=16'hFFFF. `cnt_clr` together with a stall cycle → 0. Reset mid-FLUSH → `state`=0, `flush`=0 immediately.
